// File: rtl/cmd_issuer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cmd_issuer_if
// Brief    : Command, UART byte-stream and response bundle for cmd_issuer.
// Revision : 1.0
// ============================================================================
interface cmd_issuer_if #(
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int BUFFER_WORD_SIZE = 16,
    parameter int ADDRESS_SIZE     = 9,
    parameter int OPCODE_WIDTH     = 3
) ();
    // Flags fill the instruction bits between the opcode and the reserved bit.
    localparam int c_FLAG_WIDTH = BUFFER_WORD_SIZE - ADDRESS_SIZE - 1 - OPCODE_WIDTH;

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [OPCODE_WIDTH-1:0]     cmd_opcode;
    logic [c_FLAG_WIDTH-1:0]     cmd_flags;
    logic [ADDRESS_SIZE-1:0]     cmd_addr;
    logic [BUFFER_WORD_SIZE-1:0] cmd_payload;

    logic                        tx_valid;
    logic [FIFO_DATA_WIDTH-1:0]  tx_data;
    logic                        tx_ready;

    logic                        rx_valid;
    logic [FIFO_DATA_WIDTH-1:0]  rx_data;

    logic                        resp_valid;
    logic [FIFO_DATA_WIDTH-1:0]  resp_data;
    logic                        resp_timeout;

    logic                        busy;
    logic                        halted;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_flags, cmd_addr, cmd_payload,
        input  tx_ready, rx_valid, rx_data,
        output cmd_ready, tx_valid, tx_data,
        output resp_valid, resp_data, resp_timeout, busy, halted
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_flags, cmd_addr, cmd_payload,
        output tx_ready, rx_valid, rx_data,
        input  cmd_ready, tx_valid, tx_data,
        input  resp_valid, resp_data, resp_timeout, busy, halted
    );
endinterface
`default_nettype wire

// File: rtl/cmd_issuer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cmd_issuer
// Brief    : Serialises host commands into UART bytes and collects FETCH replies.
// Revision : 1.0
// ============================================================================
module cmd_issuer #(
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int BUFFER_WORD_SIZE = 16,
    parameter int ADDRESS_SIZE     = 9,
    parameter int OPCODE_WIDTH     = 3,
    parameter int RESP_TIMEOUT     = 1000000,
    parameter bit SKIP_SELFTEST    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    cmd_issuer_if.slave bus
);

    localparam int c_CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(RESP_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [FIFO_DATA_WIDTH-1:0] c_SELFTEST_BYTE = FIFO_DATA_WIDTH'(8'hAA);

    localparam logic [OPCODE_WIDTH-1:0] c_OP_STORE = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_FETCH = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_HALT  = OPCODE_WIDTH'(4);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND_I0   = 3'd1,
        S_SEND_I1   = 3'd2,
        S_SEND_P0   = 3'd3,
        S_SEND_P1   = 3'd4,
        S_WAIT_RESP = 3'd5,
        S_HALTED    = 3'd6
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [BUFFER_WORD_SIZE-1:0] r_instr;
    logic [BUFFER_WORD_SIZE-1:0] r_payload;
    logic [c_CNT_W-1:0]          r_count;
    logic                        r_st_armed;

    logic                        w_accept;
    logic                        w_rx_take;
    logic                        w_resp_fire;
    logic                        w_resp_to;
    logic [OPCODE_WIDTH-1:0]     w_opcode;

    assign w_opcode = r_instr[OPCODE_WIDTH-1:0];
    assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;

    // The first 0xAA after reset is the far end's power-on self-test marker.
    assign w_rx_take = bus.rx_valid &&
                       !(r_st_armed && (bus.rx_data == c_SELFTEST_BYTE));

    assign bus.busy   = (r_state != S_IDLE) && (r_state != S_HALTED);
    assign bus.halted = (r_state == S_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        bus.cmd_ready = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        w_resp_fire   = 1'b0;
        w_resp_to     = 1'b0;

        case (r_state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_state_next = S_SEND_I0;
                end
            end
            S_SEND_I0: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = r_instr[FIFO_DATA_WIDTH-1:0];
                if (bus.tx_ready) begin
                    w_state_next = S_SEND_I1;
                end
            end
            S_SEND_I1: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = r_instr[2*FIFO_DATA_WIDTH-1:FIFO_DATA_WIDTH];
                if (bus.tx_ready) begin
                    if (w_opcode == c_OP_STORE) begin
                        w_state_next = S_SEND_P0;
                    end else if (w_opcode == c_OP_FETCH) begin
                        w_state_next = S_WAIT_RESP;
                    end else if (w_opcode == c_OP_HALT) begin
                        w_state_next = S_HALTED;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_SEND_P0: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = r_payload[FIFO_DATA_WIDTH-1:0];
                if (bus.tx_ready) begin
                    w_state_next = S_SEND_P1;
                end
            end
            S_SEND_P1: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = r_payload[2*FIFO_DATA_WIDTH-1:FIFO_DATA_WIDTH];
                if (bus.tx_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_RESP: begin
                // A byte landing on the last counted cycle wins over the timeout.
                if (w_rx_take) begin
                    w_resp_fire  = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_count == c_TO_LAST) begin
                    w_resp_fire  = 1'b1;
                    w_resp_to    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_HALTED: begin
                w_state_next = S_HALTED;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr          <= '0;
            r_payload        <= '0;
            r_count          <= '0;
            r_st_armed       <= SKIP_SELFTEST;
            bus.resp_valid   <= 1'b0;
            bus.resp_data    <= '0;
            bus.resp_timeout <= 1'b0;
        end else begin
            bus.resp_valid <= w_resp_fire;

            if (w_accept) begin
                r_instr   <= {bus.cmd_addr, 1'b0, bus.cmd_flags, bus.cmd_opcode};
                r_payload <= bus.cmd_payload;
            end

            if (r_state == S_WAIT_RESP) begin
                r_count <= r_count + c_CNT_ONE;
            end else begin
                r_count <= '0;
            end

            if (w_resp_fire) begin
                bus.resp_data    <= w_resp_to ? '0 : bus.rx_data;
                bus.resp_timeout <= w_resp_to;
            end

            if (bus.rx_valid) begin
                r_st_armed <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_issuer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cmd_issuer
// Brief    : Directed, table-driven self-checking bench for cmd_issuer.
// Revision : 1.0
// ============================================================================
module tb_cmd_issuer;

    localparam int c_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmd_issuer_if #(
        .FIFO_DATA_WIDTH (8),
        .BUFFER_WORD_SIZE(16),
        .ADDRESS_SIZE    (9),
        .OPCODE_WIDTH    (3)
    ) bus ();

    cmd_issuer #(
        .FIFO_DATA_WIDTH (8),
        .BUFFER_WORD_SIZE(16),
        .ADDRESS_SIZE    (9),
        .OPCODE_WIDTH    (3),
        .RESP_TIMEOUT    (c_TIMEOUT),
        .SKIP_SELFTEST   (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string           name;
        logic [2:0]      op;
        logic [2:0]      fl;
        logic [8:0]      addr;
        logic [15:0]     pay;
        bit              stall;
        int              nb;
        logic [3:0][7:0] b;
        bit              fetch;
        bit              reply;
        logic [7:0]      rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [2:0] op, input logic [2:0] fl,
                                input logic [8:0] addr, input logic [15:0] pay, input bit stall,
                                input int nb, input logic [31:0] bytes, input bit fetch,
                                input bit reply, input logic [7:0] rdata);
        vec_t v;
        v.name = name; v.op = op; v.fl = fl; v.addr = addr; v.pay = pay;
        v.stall = stall; v.nb = nb; v.b = bytes; v.fetch = fetch;
        v.reply = reply; v.rdata = rdata;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.tx_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [2:0] fl,
                            input logic [8:0] addr, input logic [15:0] pay);
        int budget = 50;
        while (!bus.cmd_ready && budget > 0) begin
            tick();
            budget--;
        end
        chk("cmd_ready_before_send", bus.cmd_ready, 1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_opcode  = op;
        bus.cmd_flags   = fl;
        bus.cmd_addr    = addr;
        bus.cmd_payload = pay;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Drains n bytes; with stall set, tx_ready alternates 1/0 starting at 1.
    task automatic collect(input string name, input int n, input bit stall,
                           output logic [3:0][7:0] got, output int cnt);
        bit         phase  = 1'b1;
        bit         held_v = 1'b0;
        logic [7:0] held   = '0;
        int         budget = 100;
        got = '0;
        cnt = 0;
        while (cnt < n && budget > 0) begin
            bus.tx_ready = stall ? phase : 1'b1;
            if (held_v) begin
                chk($sformatf("%s_hold_valid", name), bus.tx_valid, 1);
                chk($sformatf("%s_hold_data", name), bus.tx_data, held);
                held_v = 1'b0;
            end
            if (bus.tx_valid) begin
                if (bus.tx_ready) begin
                    got[cnt] = bus.tx_data;
                    cnt++;
                end else begin
                    held   = bus.tx_data;
                    held_v = 1'b1;
                end
            end
            phase = ~phase;
            tick();
            budget--;
        end
        bus.tx_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0][7:0] got;
        int              cnt;
        int              k;
        send_cmd(v.op, v.fl, v.addr, v.pay);
        chk($sformatf("%s_first_byte_valid", v.name), bus.tx_valid, 1);
        chk($sformatf("%s_busy", v.name), bus.busy, 1);
        collect(v.name, v.nb, v.stall, got, cnt);
        chk($sformatf("%s_byte_count", v.name), cnt, v.nb);
        for (int i = 0; i < v.nb; i++) begin
            chk($sformatf("%s_byte%0d", v.name, i), got[i], v.b[i]);
        end
        if (v.fetch) begin
            chk($sformatf("%s_wait_busy", v.name), bus.busy, 1);
            if (v.reply) begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = v.rdata;
                tick();
                bus.rx_valid = 1'b0;
                chk($sformatf("%s_resp_valid", v.name), bus.resp_valid, 1);
                chk($sformatf("%s_resp_data", v.name), bus.resp_data, v.rdata);
                chk($sformatf("%s_resp_timeout", v.name), bus.resp_timeout, 0);
            end else begin
                k = 0;
                while (!bus.resp_valid && k < 4 * c_TIMEOUT) begin
                    tick();
                    k++;
                end
                chk($sformatf("%s_timeout_latency", v.name), k, c_TIMEOUT);
                chk($sformatf("%s_resp_timeout", v.name), bus.resp_timeout, 1);
                chk($sformatf("%s_resp_data", v.name), bus.resp_data, 8'h00);
            end
            tick();
            chk($sformatf("%s_resp_pulse", v.name), bus.resp_valid, 0);
            chk($sformatf("%s_resp_hold", v.name), bus.resp_data, v.reply ? v.rdata : 8'h00);
            chk($sformatf("%s_ready_after", v.name), bus.cmd_ready, 1);
        end else begin
            chk($sformatf("%s_ready_after", v.name), bus.cmd_ready, 1);
            chk($sformatf("%s_idle_busy", v.name), bus.busy, 0);
        end
    endtask

    initial begin
        logic [3:0][7:0] got;
        int              cnt;

        bus.cmd_valid   = 1'b0;
        bus.cmd_opcode  = '0;
        bus.cmd_flags   = '0;
        bus.cmd_addr    = '0;
        bus.cmd_payload = '0;
        bus.tx_ready    = 1'b0;
        bus.rx_valid    = 1'b0;
        bus.rx_data     = '0;

        //           name        op    fl    addr    pay       stall nb bytes{b3,b2,b1,b0} fetch reply rdata
        vecs.push_back(mk("fetch_a", 3'd1, 3'd1, 9'h004, 16'h0000, 1'b0, 2, 32'h0000_0209, 1'b1, 1'b1, 8'h3C));
        vecs.push_back(mk("store_a", 3'd0, 3'd2, 9'h000, 16'hBEEF, 1'b1, 4, 32'hBEEF_0010, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk("run",     3'd2, 3'd7, 9'h1FF, 16'hFFFF, 1'b1, 2, 32'h0000_FFBA, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk("load",    3'd3, 3'd0, 9'h0AA, 16'h0000, 1'b0, 2, 32'h0000_5503, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk("nop",     3'd5, 3'd4, 9'h101, 16'h0000, 1'b0, 2, 32'h0000_80A5, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk("op6",     3'd6, 3'd3, 9'h002, 16'hAAAA, 1'b1, 2, 32'h0000_011E, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk("op7",     3'd7, 3'd5, 9'h0F0, 16'h5555, 1'b0, 2, 32'h0000_782F, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk("fetch_b", 3'd1, 3'd6, 9'h033, 16'h0000, 1'b1, 2, 32'h0000_19B1, 1'b1, 1'b1, 8'h5A));
        vecs.push_back(mk("fetch_o", 3'd1, 3'd1, 9'h005, 16'h0000, 1'b0, 2, 32'h0000_0289, 1'b1, 1'b1, 8'hC3));
        vecs.push_back(mk("store_b", 3'd0, 3'd7, 9'h1FE, 16'h1234, 1'b0, 4, 32'h1234_FF38, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk("fetch_t", 3'd1, 3'd0, 9'h000, 16'h0000, 1'b0, 2, 32'h0000_0001, 1'b1, 1'b0, 8'h00));

        do_reset();
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 8'h00);
        chk("rst_resp_timeout", bus.resp_timeout, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_halted", bus.halted, 0);

        // Self-test marker arrives while idle, then a FETCH whose reply is also 0xAA.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hAA;
        tick();
        bus.rx_valid = 1'b0;
        chk("selftest_idle_no_resp", bus.resp_valid, 0);
        run_vec(mk("st_fetch", 3'd1, 3'd0, 9'h000, 16'h0000, 1'b0, 2, 32'h0000_0001, 1'b1, 1'b1, 8'hAA));

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // Stray byte while idle is ignored.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h77;
        tick();
        bus.rx_valid = 1'b0;
        chk("stray_rx_no_resp", bus.resp_valid, 0);

        // Byte on the final counted cycle beats the timeout.
        send_cmd(3'd1, 3'd0, 9'h000, 16'h0000);
        collect("edge", 2, 1'b0, got, cnt);
        for (int i = 0; i < c_TIMEOUT - 1; i++) tick();
        chk("edge_no_early_resp", bus.resp_valid, 0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h66;
        tick();
        bus.rx_valid = 1'b0;
        chk("edge_resp_valid", bus.resp_valid, 1);
        chk("edge_resp_data", bus.resp_data, 8'h66);
        chk("edge_resp_timeout", bus.resp_timeout, 0);
        tick();

        // Reset after the instruction bytes of a STORE.
        send_cmd(3'd0, 3'd2, 9'h000, 16'hBEEF);
        collect("rst_store", 2, 1'b0, got, cnt);
        chk("rst_store_mid_valid", bus.tx_valid, 1);
        do_reset();
        chk("rst_store_tx_valid", bus.tx_valid, 0);
        chk("rst_store_cmd_ready", bus.cmd_ready, 1);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_store_quiet", bus.tx_valid, 0);
        end
        bus.tx_ready = 1'b0;
        run_vec(mk("after_rst", 3'd2, 3'd7, 9'h1FF, 16'h0000, 1'b0, 2, 32'h0000_FFBA, 1'b0, 1'b0, 8'h00));

        // Reset while waiting for a reply; a late byte must not produce a response.
        send_cmd(3'd1, 3'd0, 9'h000, 16'h0000);
        collect("rst_wait", 2, 1'b0, got, cnt);
        tick();
        tick();
        do_reset();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h3C;
        tick();
        bus.rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_wait_no_resp", bus.resp_valid, 0);
            tick();
        end

        // Filter re-armed by reset: 0xAA inside WAIT_RESP is dropped, the next one returned.
        do_reset();
        send_cmd(3'd1, 3'd0, 9'h000, 16'h0000);
        collect("st_wait", 2, 1'b0, got, cnt);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hAA;
        tick();
        chk("st_wait_dropped", bus.resp_valid, 0);
        chk("st_wait_still_busy", bus.busy, 1);
        tick();
        bus.rx_valid = 1'b0;
        chk("st_wait_resp_valid", bus.resp_valid, 1);
        chk("st_wait_resp_data", bus.resp_data, 8'hAA);
        tick();

        // A non-0xAA first byte disarms the filter and is delivered.
        do_reset();
        run_vec(mk("st_other", 3'd1, 3'd0, 9'h000, 16'h0000, 1'b0, 2, 32'h0000_0001, 1'b1, 1'b1, 8'h11));
        run_vec(mk("st_disarm", 3'd1, 3'd0, 9'h000, 16'h0000, 1'b0, 2, 32'h0000_0001, 1'b1, 1'b1, 8'hAA));

        // HALT is absorbing until reset.
        send_cmd(3'd4, 3'd0, 9'h000, 16'h0000);
        collect("halt", 2, 1'b0, got, cnt);
        chk("halt_count", cnt, 2);
        chk("halt_byte0", got[0], 8'h04);
        chk("halt_byte1", got[1], 8'h00);
        chk("halt_halted", bus.halted, 1);
        chk("halt_busy", bus.busy, 0);
        bus.cmd_valid = 1'b1;
        bus.tx_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("halt_cmd_ready", bus.cmd_ready, 0);
            chk("halt_tx_valid", bus.tx_valid, 0);
            tick();
        end
        chk("halt_still_halted", bus.halted, 1);
        do_reset();
        chk("halt_rst_cmd_ready", bus.cmd_ready, 1);
        chk("halt_rst_halted", bus.halted, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
